// File: rtl/fw_local_intc_pkg.sv
// fw_local_intc_pkg
// Constants shared by the local interrupt controller, its register
// front-end and the per-source conditioning stage.
//   FW_INTC_MODE_LEVEL / FW_INTC_MODE_EDGE : per-source request mode encoding
//   FW_INTC_FILT_CYCLES_DEF                : default glitch-filter length
// Optional feature macro used by the conditioning stage:
//   FW_LOCAL_INTC_SRC_FILTER_EN
package fw_local_intc_pkg;

  localparam logic FW_INTC_MODE_LEVEL = 1'b0;
  localparam logic FW_INTC_MODE_EDGE  = 1'b1;

  localparam int unsigned FW_INTC_FILT_CYCLES_DEF = 4;

endpackage

// File: rtl/fw_local_intc_src_chan.sv
// fw_local_intc_src_chan
// One interrupt source: two-flop synchronizer, optional glitch filter,
// polarity, rising-edge latch and registered output.
// Ports:
//   clock      block clock
//   reset      asynchronous active-low reset
//   raw_src    asynchronous raw interrupt line
//   invert     1 = source is active-low (quasi-static, clock domain)
//   edge_mode  1 = latched rising edge, 0 = level (clock domain)
//   clear      single-cycle clear of a latched edge request
//   src        conditioned request to the interrupt controller
// Macro FW_LOCAL_INTC_SRC_FILTER_EN: when defined, a FILT_CYCLES-sample
// glitch filter sits between the synchronizer and the polarity stage.
module fw_local_intc_src_chan
  import fw_local_intc_pkg::*;
#(
  parameter int unsigned FILT_CYCLES = FW_INTC_FILT_CYCLES_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_src,
  input  logic invert,
  input  logic edge_mode,
  input  logic clear,
  output logic src
);

  logic s1;
  logic s2;
  logic filt;
  logic act;
  logic prev;

  if (FILT_CYCLES < 1) begin : g_bad_filt
    $error("FILT_CYCLES must be at least 1");
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw_src;
      s2 <= s1;
    end
  end

`ifdef FW_LOCAL_INTC_SRC_FILTER_EN
  // Counter is at least one bit wide so FILT_CYCLES=1 still elaborates;
  // in that case cnt is always 0 and every change is accepted at once.
  localparam int unsigned CW = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic          filt_q;

  // A sample matching the accepted value restarts the run, so only
  // FILT_CYCLES consecutive differing samples move filt.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      filt_q <= 1'b0;
      cnt    <= '0;
    end else if (s2 == filt_q) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      filt_q <= s2;
      cnt    <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign filt = filt_q;
`else
  assign filt = s2;
`endif

  assign act = filt ^ invert;

  // prev resets to 0, so a line already active at reset release (including
  // an idle active-low line) latches exactly one edge request.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev <= 1'b0;
      src  <= 1'b0;
    end else begin
      prev <= act;
      unique case (edge_mode)
        FW_INTC_MODE_LEVEL: src <= act;
        FW_INTC_MODE_EDGE: begin
          // set has priority over a coincident clear
          if (act && !prev) begin
            src <= 1'b1;
          end else if (clear) begin
            src <= 1'b0;
          end
        end
        default: src <= src;
      endcase
    end
  end

endmodule

// File: rtl/fw_local_intc_src_cond.sv
// fw_local_intc_src_cond
// Per-source interrupt conditioning in front of fw_local_intc_wb. Each of
// the N_SRCS raw lines is synchronized, optionally glitch-filtered,
// polarity-corrected and presented as a level or latched-edge request.
// Ports:
//   clock      block clock
//   reset      asynchronous active-low reset
//   raw_src    [N_SRCS] asynchronous raw interrupt inputs
//   invert     [N_SRCS] per-source active-low select
//   edge_mode  [N_SRCS] per-source mode (1 = edge, 0 = level)
//   clear      [N_SRCS] clear pulses for latched edge requests
//   src        [N_SRCS] conditioned requests, bit-for-bit to the controller
// Macro FW_LOCAL_INTC_SRC_FILTER_EN: enables the FILT_CYCLES glitch filter
// on every source (latency 3+FILT_CYCLES instead of 3).
module fw_local_intc_src_cond
  import fw_local_intc_pkg::*;
#(
  parameter int unsigned N_SRCS      = 1,
  parameter int unsigned FILT_CYCLES = FW_INTC_FILT_CYCLES_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_SRCS-1:0] raw_src,
  input  logic [N_SRCS-1:0] invert,
  input  logic [N_SRCS-1:0] edge_mode,
  input  logic [N_SRCS-1:0] clear,
  output logic [N_SRCS-1:0] src
);

  for (genvar i = 0; i < N_SRCS; i++) begin : g_chan
    fw_local_intc_src_chan #(
      .FILT_CYCLES(FILT_CYCLES)
    ) u_chan (
      .clock     (clock),
      .reset     (reset),
      .raw_src   (raw_src[i]),
      .invert    (invert[i]),
      .edge_mode (edge_mode[i]),
      .clear     (clear[i]),
      .src       (src[i])
    );
  end

endmodule

// File: tb/tb_fw_local_intc_src_cond.sv
module tb_fw_local_intc_src_cond;

  localparam int N = 4;
  localparam int F = 4;
`ifdef FW_LOCAL_INTC_SRC_FILTER_EN
  localparam int LAT = 3 + F;
  localparam int PW  = F;
`else
  localparam int LAT = 3;
  localparam int PW  = 1;
`endif

  logic         clock;
  logic         reset;
  logic [N-1:0] raw_src;
  logic [N-1:0] invert;
  logic [N-1:0] edge_mode;
  logic [N-1:0] clear;
  logic [N-1:0] src;

  int n_checks = 0;
  int n_fail   = 0;

  fw_local_intc_src_cond #(
    .N_SRCS      (N),
    .FILT_CYCLES (F)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .raw_src   (raw_src),
    .invert    (invert),
    .edge_mode (edge_mode),
    .clear     (clear),
    .src       (src)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference model: history of raw samples (q[0] newest), filtered value
  // defined as "last F synchronized samples all differ from the accepted
  // value", and an edge latch driven by the previous active level.
  bit   [N-1:0] q[$];
  logic [N-1:0] m_filt;
  logic [N-1:0] m_prev;
  logic [N-1:0] m_src;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      q.delete();
      for (int j = 0; j < F + 2; j++) q.push_back('0);
      m_filt = '0;
      m_prev = '0;
      m_src  = '0;
    end else begin
      logic [N-1:0] fv;
      logic [N-1:0] act;
`ifdef FW_LOCAL_INTC_SRC_FILTER_EN
      logic [N-1:0] nf;
      int nd;
      fv = m_filt;
      nf = m_filt;
      for (int b = 0; b < N; b++) begin
        nd = 0;
        for (int j = 1; j <= F; j++) if (q[j][b] != m_filt[b]) nd++;
        if (nd == F) nf[b] = ~m_filt[b];
      end
`else
      fv = q[1];
`endif
      act = fv ^ invert;
      for (int b = 0; b < N; b++) begin
        if (!edge_mode[b]) m_src[b] = act[b];
        else if (act[b] && !m_prev[b]) m_src[b] = 1'b1;
        else if (clear[b]) m_src[b] = 1'b0;
      end
      m_prev = act;
`ifdef FW_LOCAL_INTC_SRC_FILTER_EN
      m_filt = nf;
`endif
      q.push_front(raw_src);
      void'(q.pop_back());
    end
  end

  task automatic quiesce;
    @(negedge clock);
    raw_src   = '0;
    invert    = '0;
    edge_mode = '0;
    clear     = '1;
    @(negedge clock);
    clear = '0;
    repeat (LAT + F + 2) @(negedge clock);
  endtask

  task automatic test_reset;
    raw_src   = '0;
    invert    = '0;
    edge_mode = '0;
    clear     = '0;
    reset     = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    n_checks++;
    if (src !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_value: src=%b exp=%b", src, 4'b0000);
    end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_level;
    logic [N-1:0] exp;
    quiesce();
    raw_src[2] = 1'b1;
    for (int e = 1; e <= LAT; e++) begin
      @(posedge clock); #1;
      exp = (e == LAT) ? 4'b0100 : 4'b0000;
      n_checks++;
      if (src !== exp) begin
        n_fail++;
        $display("FAIL level_rise e%0d: src=%b exp=%b", e, src, exp);
      end
    end
    repeat (3) @(negedge clock);
    raw_src[2] = 1'b0;
    for (int e = 1; e <= LAT; e++) begin
      @(posedge clock); #1;
      exp = (e == LAT) ? 4'b0000 : 4'b0100;
      n_checks++;
      if (src !== exp) begin
        n_fail++;
        $display("FAIL level_fall e%0d: src=%b exp=%b", e, src, exp);
      end
    end
  endtask

  task automatic test_edge;
    logic [N-1:0] exp;
    quiesce();
    edge_mode = 4'b0001;
    @(negedge clock);
    raw_src[0] = 1'b1;
    for (int e = 1; e <= LAT; e++) begin
      @(posedge clock); #1;
      exp = (e == LAT) ? 4'b0001 : 4'b0000;
      n_checks++;
      if (src !== exp) begin
        n_fail++;
        $display("FAIL edge_set e%0d: src=%b exp=%b", e, src, exp);
      end
      if (e == PW) begin
        @(negedge clock);
        raw_src[0] = 1'b0;
      end
    end
    for (int c = 0; c < 20; c++) begin
      @(posedge clock); #1;
      n_checks++;
      if (src !== 4'b0001) begin
        n_fail++;
        $display("FAIL edge_hold c%0d: src=%b exp=%b", c, src, 4'b0001);
      end
    end
    @(negedge clock);
    clear[0] = 1'b1;
    @(posedge clock); #1;
    n_checks++;
    if (src !== 4'b0000) begin
      n_fail++;
      $display("FAIL edge_clear: src=%b exp=%b", src, 4'b0000);
    end
    @(negedge clock);
    clear[0] = 1'b0;
  endtask

  task automatic test_set_clear;
    quiesce();
    edge_mode = 4'b0010;
    @(negedge clock);
    raw_src[1] = 1'b1;
    repeat (LAT - 1) @(posedge clock);
    @(negedge clock);
    clear[1] = 1'b1;
    @(posedge clock); #1;
    n_checks++;
    if (src[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL set_beats_clear: src[1]=%b exp=1", src[1]);
    end
    @(negedge clock);
    clear[1] = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    n_checks++;
    if (src[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL sustained_once_hold: src[1]=%b exp=1", src[1]);
    end
    @(negedge clock);
    clear[1] = 1'b1;
    @(negedge clock);
    clear[1] = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    n_checks++;
    if (src[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL sustained_no_rearm: src[1]=%b exp=0", src[1]);
    end
  endtask

`ifdef FW_LOCAL_INTC_SRC_FILTER_EN
  task automatic test_filter;
    logic [N-1:0] exp;
    quiesce();
    raw_src[2] = 1'b1;
    repeat (F - 1) @(negedge clock);
    raw_src[2] = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clock); #1;
      n_checks++;
      if (src !== 4'b0000) begin
        n_fail++;
        $display("FAIL filt_short c%0d: src=%b exp=%b", c, src, 4'b0000);
      end
    end
    @(negedge clock);
    raw_src[2] = 1'b1;
    for (int e = 1; e <= 3 + F; e++) begin
      @(posedge clock); #1;
      exp = (e == 3 + F) ? 4'b0100 : 4'b0000;
      n_checks++;
      if (src !== exp) begin
        n_fail++;
        $display("FAIL filt_accept e%0d: src=%b exp=%b", e, src, exp);
      end
    end
    quiesce();
    for (int c = 0; c < 40; c++) begin
      if (c % 2 == 0) raw_src[2] = ~raw_src[2];
      @(posedge clock); #1;
      n_checks++;
      if (src !== 4'b0000) begin
        n_fail++;
        $display("FAIL filt_toggle c%0d: src=%b exp=%b", c, src, 4'b0000);
      end
      @(negedge clock);
    end
    raw_src[2] = 1'b0;
  endtask
`endif

  task automatic test_polarity_reset;
    quiesce();
    reset     = 1'b0;
    invert    = 4'b1000;
    edge_mode = 4'b1000;
    raw_src   = 4'b0000;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    n_checks++;
    if (src !== 4'b1000) begin
      n_fail++;
      $display("FAIL pol_release: src=%b exp=%b", src, 4'b1000);
    end
    repeat (10) @(posedge clock);
    #1;
    n_checks++;
    if (src !== 4'b1000) begin
      n_fail++;
      $display("FAIL pol_hold: src=%b exp=%b", src, 4'b1000);
    end
    @(negedge clock);
    clear[3] = 1'b1;
    @(negedge clock);
    clear[3] = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clock); #1;
      n_checks++;
      if (src !== 4'b0000) begin
        n_fail++;
        $display("FAIL pol_no_reassert c%0d: src=%b exp=%b", c, src, 4'b0000);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [N-1:0] exp;
    quiesce();
    raw_src = 4'b1011;
    repeat (LAT + 2) @(posedge clock);
    #1;
    n_checks++;
    if (src !== 4'b1011) begin
      n_fail++;
      $display("FAIL mid_pending: src=%b exp=%b", src, 4'b1011);
    end
    #1;
    reset = 1'b0;
    #1;
    n_checks++;
    if (src !== 4'b0000) begin
      n_fail++;
      $display("FAIL mid_async_clear: src=%b exp=%b", src, 4'b0000);
    end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    for (int e = 1; e <= LAT; e++) begin
      @(posedge clock); #1;
      exp = (e == LAT) ? 4'b1011 : 4'b0000;
      n_checks++;
      if (src !== exp) begin
        n_fail++;
        $display("FAIL mid_reacquire e%0d: src=%b exp=%b", e, src, exp);
      end
    end
  endtask

  task automatic test_random;
    quiesce();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if (i == 1503) reset = 1'b1;
      if ($urandom_range(0, 5) == 0) raw_src[$urandom_range(0, N - 1)] ^= 1'b1;
      if ($urandom_range(0, 49) == 0) invert = N'($urandom);
      if ($urandom_range(0, 49) == 0) edge_mode = N'($urandom);
      for (int b = 0; b < N; b++) clear[b] = ($urandom_range(0, 7) == 0);
      @(posedge clock); #1;
      n_checks++;
      if (src !== m_src) begin
        n_fail++;
        $display("FAIL random i%0d: src=%b exp=%b", i, src, m_src);
      end
      if (i == 1500) begin
        #2;
        reset = 1'b0;
      end
    end
    clear = '0;
  endtask

  initial begin
    test_reset();
    test_level();
    test_edge();
    test_set_clear();
`ifdef FW_LOCAL_INTC_SRC_FILTER_EN
    test_filter();
`endif
    test_polarity_reset();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fw_local_intc_src_cond.md
# fw_local_intc_src_cond

Per-source interrupt conditioning stage placed directly upstream of the local interrupt controller. Synchronizes N asynchronous raw interrupt lines into the `clock` domain, optionally glitch-filters them, applies per-source polarity, and presents each as a level or a latched-edge request on `src`. The `src` bus connects bit-for-bit to the `src` input of `fw_local_intc_wb`.

## Interface
Parameters:
- `N_SRCS`, 1: number of interrupt sources.
- `FILT_CYCLES`, 4: consecutive stable samples needed to accept a change. Legal range ≥1. Only used when the filter is compiled in.

Ports:
- `clock`  in  1  the single block clock.
- `reset`  in  1  asynchronous, active-low reset. All state clears while `reset`=0.
- `raw_src`  in  N_SRCS  asynchronous raw interrupt inputs.
- `invert`  in  N_SRCS  per-source polarity. 1 means the source is active-low. Quasi-static.
- `edge_mode`  in  N_SRCS  per-source mode. 1 = latched rising edge (after `invert` is applied), 0 = level.
- `clear`  in  N_SRCS  single-cycle clear pulse for latched edge requests. Ignored in level mode.
- `src`  out  N_SRCS  registered conditioned requests sent to the interrupt controller.

## Operation
Each source is handled independently. The pipeline for one source is:
- **Sync:** two flops, `s1` then `s2`, sampling `raw_src`. Reset value 0.
- **Filter** (compiled in only): state `filt` and counter `cnt`, width $clog2(FILT_CYCLES).
  - `s2`==`filt`: `cnt`<=0.
  - Else if `cnt`==FILT_CYCLES-1: `filt`<=`s2`, `cnt`<=0.
  - Else: `cnt`<=`cnt`+1.
  - Any sample that matches `filt` restarts the count. Pulses shorter than FILT_CYCLES samples are therefore discarded.
  - When the filter is compiled out, `filt` is simply `s2`.
- **Polarity:** `act` = `filt` ^ `invert`. This is combinational.
- **Edge detect:** `prev`<=`act` every cycle. Reset value 0.
- **Output register `src`:**
  - Level mode: `src`<=`act`.
  - Edge mode: if `act` & ~`prev`, then `src`<=1. Else if `clear`, then `src`<=0. Otherwise `src` holds.
  - If a set and a clear happen in the same cycle, the set wins and `src` stays 1.

Boundary cases:
- **Reset exit with an active input:** `prev` resets to 0. An input that is active at reset release (including an active-low idle line with `invert`=1) produces exactly one latched request in edge mode. Software clears it.
- **Mode switch edge→level:** `src` follows `act` from the next edge.
- **Mode switch level→edge:** `src` holds its current value until the next set or clear.
- **`clear` while not pending:** no effect.
- **Sustained active level in edge mode:** sets `src` only once. It re-arms only after `act` returns to 0.
- **Reset asserted mid-operation:** `s1`, `s2`, `filt`, `cnt`, `prev` and `src` all go to 0 immediately and asynchronously.

## Timing
- **Reset values:** `src`=0 and all internal state = 0.
- **Latency without the filter:** `raw_src` changes before edge E1. `s1` updates at E1, `s2` at E2, and `src` at E3. That is 3 edges.
- **Latency with the filter:** `filt` updates at edge E(2+FILT_CYCLES) and `src` at E(3+FILT_CYCLES).
- **Minimum accepted pulse with the filter:** FILT_CYCLES clock periods (plus synchronizer uncertainty).
- **`clear` latency:** `clear` sampled at edge E drives `src`=0 after E.
- **Config inputs:** `invert` and `edge_mode` take effect at the next edge. They are not synchronized and are driven from `clock`-domain registers.

## Configuration
- **Macro:** `FW_LOCAL_INTC_SRC_FILTER_EN`.
- **Defined:** the glitch filter and its counter are instantiated for every source. Latency is 3+FILT_CYCLES.
- **Undefined:** no filter logic is generated, `filt`=`s2`, latency is 3, and `FILT_CYCLES` is ignored.

## Structure
- **Shared package `fw_local_intc_pkg`:** holds the mode constants `FW_INTC_MODE_LEVEL`=0 and `FW_INTC_MODE_EDGE`=1, plus the default `FILT_CYCLES` constant. The controller and its register front-end use the same package.
- **Sub-module `fw_local_intc_src_chan`:** one source (sync, filter, polarity, edge, output flop). The top generates N_SRCS instances.

## Test plan
- **Level, no filter, N_SRCS=4:** raise `raw_src[2]` → `src[2]`=1 exactly 3 edges later. Lower it → `src[2]`=0 3 edges later. Other bits stay 0.
- **Edge mode, `invert`=0:** 1-cycle pulse on `raw_src[0]` → `src[0]`=1 and held for 20 cycles. Pulse `clear[0]` → `src[0]`=0 the next edge.
- **Simultaneous set and clear:** arrange a rising `act` in the same cycle as `clear[1]` → `src[1]` stays 1.
- **Filter on, FILT_CYCLES=4:**
  - 3-cycle pulse → `src` never asserts.
  - 4-cycle-or-longer pulse → `src`=1 at edge 7 after the change.
  - Toggling every 2 cycles → `src` stays 0.
- **Polarity plus reset release:** `invert[3]`=1, `edge_mode[3]`=1, `raw_src[3]`=0 held through reset → one latched `src[3]`=1 after release. Clear it → no re-assertion.
- **Reset mid-operation:** assert `reset`=0 with `src`=4'b1011 pending → `src`=0 immediately (async). After release, sources in level mode reacquire after 3 edges.
